// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope block.
package adsr_pkg;
  localparam int ENV_W = 16;
  localparam logic [ENV_W-1:0] ENV_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;
endpackage

// File: rtl/adsr_vca.sv
// Two-stage VCA: registers operands, then registers floor(sample * level / 2^16).
module adsr_vca
  import adsr_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      sample_in,
  input  logic [ENV_W-1:0] level,
  output logic [15:0]      sample_out
);
  logic [15:0]         s_q;
  logic [ENV_W-1:0]    l_q;
  logic signed [32:0]  product;
  logic                unused_bits;

  // level is zero-extended so 0xFFFF stays positive; the result never overflows 16 bits
  assign product     = $signed(s_q) * $signed({1'b0, l_q});
  assign unused_bits = ^{product[32], product[15:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q        <= '0;
      l_q        <= '0;
      sample_out <= '0;
    end else begin
      s_q        <= sample_in;
      l_q        <= level;
      sample_out <= product[31:16];
    end
  end
endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope with prescaled update tick and 2-cycle VCA.
// Optional: ADSR_HARD_RESTART_EN zeroes the level when a rise retriggers ATTACK.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int PRESCALE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gate,
  input  logic [15:0] sample_in,
  input  logic [15:0] attack_rate,
  input  logic [15:0] decay_rate,
  input  logic [15:0] sustain_level,
  input  logic [15:0] release_rate,
  output logic [15:0] sample_out,
  output logic [15:0] level_out,
  output logic [2:0]  state_out,
  output logic        active
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0]    cnt;
  logic             tick, gate_q, rise, fall;
  adsr_state_e      state;
  logic [ENV_W-1:0] level;
  logic [ENV_W:0]   att_sum, dec_lim;

  assign tick    = (cnt == CW'(PRESCALE - 1));
  assign rise    = gate & ~gate_q;
  assign fall    = ~gate & gate_q;
  assign att_sum = {1'b0, level} + {1'b0, attack_rate};
  // level - decay <= sustain, rearranged to avoid an underflowing subtraction
  assign dec_lim = {1'b0, sustain_level} + {1'b0, decay_rate};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      level  <= '0;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        if (state == ST_IDLE || state == ST_RELEASE) begin
          state <= ST_ATTACK;
`ifdef ADSR_HARD_RESTART_EN
          level <= '0;
`else
          level <= level;
`endif
        end
      end else if (fall) begin
        if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)
          state <= ST_RELEASE;
      end else if (tick) begin
        case (state)
          ST_ATTACK: begin
            if (attack_rate == '0 || att_sum >= {1'b0, ENV_MAX}) begin
              level <= ENV_MAX;
              state <= ST_DECAY;
            end else begin
              level <= att_sum[ENV_W-1:0];
            end
          end
          ST_DECAY: begin
            if (decay_rate == '0 || {1'b0, level} <= dec_lim) begin
              level <= sustain_level;
              state <= ST_SUSTAIN;
            end else begin
              level <= level - decay_rate;
            end
          end
          ST_SUSTAIN: level <= sustain_level;
          ST_RELEASE: begin
            if (release_rate == '0 || level <= release_rate) begin
              level <= '0;
              state <= ST_IDLE;
            end else begin
              level <= level - release_rate;
            end
          end
          ST_IDLE: level <= '0;
          default: begin
            level <= '0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign level_out = level;
  assign state_out = state;
  assign active    = (state != ST_IDLE);

  adsr_vca u_vca (
    .clk        (clk),
    .reset      (reset),
    .sample_in  (sample_in),
    .level      (level),
    .sample_out (sample_out)
  );
endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized self-checking bench: two instances (PRESCALE 1 and 4) against an arithmetic model.
module tb_adsr_envelope;
  localparam int S_IDLE = 0, S_ATT = 1, S_DEC = 2, S_SUS = 3, S_REL = 4;

  logic clk = 1'b0;
  logic reset, gate;
  logic [15:0] sample_in, attack_rate, decay_rate, sustain_level, release_rate;
  logic [15:0] so1, lv1, so4, lv4;
  logic [2:0]  st1, st4;
  logic        ac1, ac4;

  int vectors = 0, miscompares = 0;

  int m_state[2], m_level[2], m_cnt[2], m_gq[2], m_s1[2], m_l1[2], m_out[2];

  always #5 clk = ~clk;

  adsr_envelope #(.PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .gate(gate), .sample_in(sample_in),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .sample_out(so1), .level_out(lv1), .state_out(st1), .active(ac1));

  adsr_envelope #(.PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .gate(gate), .sample_in(sample_in),
    .attack_rate(attack_rate), .decay_rate(decay_rate),
    .sustain_level(sustain_level), .release_rate(release_rate),
    .sample_out(so4), .level_out(lv4), .state_out(st4), .active(ac4));

  function automatic int ps(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = S_IDLE; m_level[i] = 0; m_cnt[i] = 0; m_gq[i] = 0;
      m_s1[i] = 0; m_l1[i] = 0; m_out[i] = 0;
    end
  endtask

  // One clock of envelope behaviour expressed as plain integer arithmetic.
  task automatic model_step(input int i);
    int lv, st, a, d, s, r, g;
    bit rs, fl, tk;
    if (reset) begin
      m_state[i] = S_IDLE; m_level[i] = 0; m_cnt[i] = 0; m_gq[i] = 0;
      m_s1[i] = 0; m_l1[i] = 0; m_out[i] = 0;
      return;
    end
    a = int'(attack_rate); d = int'(decay_rate); s = int'(sustain_level);
    r = int'(release_rate); g = int'(gate);
    rs = (g == 1) && (m_gq[i] == 0);
    fl = (g == 0) && (m_gq[i] == 1);
    tk = (m_cnt[i] == ps(i) - 1);
    m_out[i] = int'((longint'(m_s1[i]) * longint'(m_l1[i])) >>> 16);
    m_s1[i]  = int'($signed(sample_in));
    m_l1[i]  = m_level[i];
    m_cnt[i] = tk ? 0 : m_cnt[i] + 1;
    m_gq[i]  = g;
    lv = m_level[i]; st = m_state[i];
    if (rs) begin
      if (st == S_IDLE || st == S_REL) begin
        st = S_ATT;
`ifdef ADSR_HARD_RESTART_EN
        lv = 0;
`endif
      end
    end else if (fl) begin
      if (st == S_ATT || st == S_DEC || st == S_SUS) st = S_REL;
    end else if (tk) begin
      case (st)
        S_ATT: if (a == 0 || lv + a >= 65535) begin lv = 65535; st = S_DEC; end else lv = lv + a;
        S_DEC: if (d == 0 || lv - d <= s) begin lv = s; st = S_SUS; end else lv = lv - d;
        S_SUS: lv = s;
        S_REL: if (r == 0 || lv <= r) begin lv = 0; st = S_IDLE; end else lv = lv - r;
        default: lv = 0;
      endcase
    end
    m_level[i] = lv; m_state[i] = st;
  endtask

  function automatic logic [35:0] mexp(input int i);
    return {16'(m_level[i]), 3'(m_state[i]), (m_state[i] != 0), 16'(m_out[i])};
  endfunction

  function automatic logic [35:0] obs(input int i);
    return (i == 0) ? {lv1, st1, ac1, so1} : {lv4, st4, ac4, so4};
  endfunction

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  task automatic settle();
    gate = 1'b0; release_rate = 16'h0000;
    for (int c = 0; c < 12; c++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1; gate = 1'b0; sample_in = 16'h7FFF;
    attack_rate = 16'h0100; decay_rate = 16'h0100;
    sustain_level = 16'h8000; release_rate = 16'h0100;
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== 36'h0) begin
        miscompares++;
        $display("FAIL reset_init inst%0d got %h want %h", i, obs(i), 36'h0);
      end
    end
    reset = 1'b0;
    gate = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample_in = 16'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL reset_attack inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
    end
    #2 reset = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== 36'h0) begin
        miscompares++;
        $display("FAIL reset_midnote inst%0d got %h want %h", i, obs(i), 36'h0);
      end
    end
    gate = 1'b0;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs(i) !== mexp(i)) begin
        miscompares++;
        $display("FAIL reset_release inst%0d got %h want %h", i, obs(i), mexp(i));
      end
    end
  endtask

  task automatic test_full_cycle();
    int t_att, t_dec, t_sus, t_rel, t_idle;
    logic [15:0] l_dec, l_sus, l_hold;
    logic [2:0]  s_hold;
    t_att = -1; t_dec = -1; t_sus = -1; t_rel = -1; t_idle = -1;
    l_dec = '0; l_sus = '0; l_hold = '0; s_hold = '0;
    attack_rate = 16'h1000; decay_rate = 16'h0800;
    sustain_level = 16'h8000; release_rate = 16'h2000;
    for (int c = 0; c < 80; c++) begin
      gate = (c < 60);
      sample_in = 16'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL full_cycle inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
      if (st1 == 3'd1 && t_att < 0) t_att = c;
      if (st1 == 3'd2 && t_dec < 0) begin t_dec = c; l_dec = lv1; end
      if (st1 == 3'd3 && t_sus < 0) begin t_sus = c; l_sus = lv1; end
      if (c == 59) begin s_hold = st1; l_hold = lv1; end
      if (st1 == 3'd4 && t_rel < 0) t_rel = c;
      if (st1 == 3'd0 && t_rel >= 0 && t_idle < 0) t_idle = c;
    end
    vectors++;
    if (t_dec - t_att !== 16 || l_dec !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL attack_ticks got %0d lvl %h want 16 lvl ffff", t_dec - t_att, l_dec);
    end
    vectors++;
    if (t_sus - t_dec !== 16 || l_sus !== 16'h8000) begin
      miscompares++;
      $display("FAIL decay_to_sustain got %0d lvl %h want 16 lvl 8000", t_sus - t_dec, l_sus);
    end
    vectors++;
    if (s_hold !== 3'd3 || l_hold !== 16'h8000) begin
      miscompares++;
      $display("FAIL sustain_hold got st %0d lvl %h want st 3 lvl 8000", s_hold, l_hold);
    end
    vectors++;
    if (t_rel !== 60 || t_idle - t_rel !== 4 || lv1 !== 16'h0) begin
      miscompares++;
      $display("FAIL release_ticks got rel@%0d ticks %0d lvl %h want rel@60 ticks 4 lvl 0",
               t_rel, t_idle - t_rel, lv1);
    end
  endtask

  task automatic test_instant();
    logic [2:0]  sh[16];
    logic [15:0] lh[16];
    settle();
    attack_rate = 16'h0; decay_rate = 16'h0;
    sustain_level = 16'h1234; release_rate = 16'h0;
    for (int c = 0; c < 16; c++) begin
      gate = (c < 10);
      sample_in = 16'($urandom);
      step();
      sh[c] = st1; lh[c] = lv1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL instant inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
    end
    vectors++;
    if ({sh[0], sh[1], lh[1], sh[2], lh[2]} !== {3'd1, 3'd2, 16'hFFFF, 3'd3, 16'h1234}) begin
      miscompares++;
      $display("FAIL instant_attack got %0d %0d %h %0d %h want 1 2 ffff 3 1234",
               sh[0], sh[1], lh[1], sh[2], lh[2]);
    end
    vectors++;
    if ({sh[10], sh[11], lh[11]} !== {3'd4, 3'd0, 16'h0}) begin
      miscompares++;
      $display("FAIL instant_release got %0d %0d %h want 4 0 0", sh[10], sh[11], lh[11]);
    end
  endtask

  task automatic test_prescaler();
    logic [15:0] hist[50];
    int nchg, last, bad;
    logic [15:0] l40;
    settle();
    attack_rate = 16'h0100; decay_rate = 16'h0100;
    sustain_level = 16'h8000; release_rate = 16'h0100;
    gate = 1'b1; l40 = '0;
    for (int c = 0; c < 50; c++) begin
      sample_in = 16'($urandom);
      step();
      hist[c] = lv4;
      if (c == 40) l40 = lv1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL prescaler inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
    end
    nchg = 0; last = -1; bad = 0;
    for (int c = 1; c < 50; c++) begin
      if (hist[c] != hist[c-1]) begin
        if (hist[c] - hist[c-1] != 16'h0100) bad++;
        if (last >= 0 && c - last != 4) bad++;
        last = c; nchg++;
      end
    end
    vectors++;
    if (bad !== 0 || nchg < 11) begin
      miscompares++;
      $display("FAIL prescale4_spacing got bad %0d changes %0d want bad 0 changes >=11", bad, nchg);
    end
    vectors++;
    if (l40 !== 16'h2800) begin
      miscompares++;
      $display("FAIL prescale1_rate got %h want 2800", l40);
    end
  endtask

  task automatic test_vca();
    logic [15:0] o1, o4;
    settle();
    attack_rate = 16'h0; decay_rate = 16'h0;
    sustain_level = 16'hFFFF; gate = 1'b1;
    for (int c = 0; c < 22; c++) begin
      if (c == 12) sustain_level = 16'hFFFF;
      if (c == 15) sustain_level = 16'h8000;
      sample_in = (c >= 12 && c < 15) ? 16'h8000 : (c >= 19) ? 16'h4000 : 16'($urandom);
      step();
      if (c == 14) begin o1 = so1; o4 = so4; end
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL vca inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
    end
    vectors++;
    if (o1 !== 16'h8000 || o4 !== 16'h8000) begin
      miscompares++;
      $display("FAIL vca_fullscale got %h %h want 8000 8000", o1, o4);
    end
    vectors++;
    if (so1 !== 16'h2000 || so4 !== 16'h2000) begin
      miscompares++;
      $display("FAIL vca_half got %h %h want 2000 2000", so1, so4);
    end
  endtask

  task automatic test_retrigger();
    logic [15:0] exp0;
`ifdef ADSR_HARD_RESTART_EN
    exp0 = 16'h0000;
`else
    exp0 = 16'h4000;
`endif
    settle();
    attack_rate = 16'h1000; decay_rate = 16'h0800;
    sustain_level = 16'h8000; release_rate = 16'h2000;
    for (int c = 0; c < 66; c++) begin
      gate = (c < 60) || (c >= 63);
      sample_in = 16'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL retrigger inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
      if (c == 62) begin
        vectors++;
        if (st1 !== 3'd4 || lv1 !== 16'h4000) begin
          miscompares++;
          $display("FAIL retrig_setup got st %0d lvl %h want st 4 lvl 4000", st1, lv1);
        end
      end
      if (c == 63) begin
        vectors++;
        if (st1 !== 3'd1 || lv1 !== exp0) begin
          miscompares++;
          $display("FAIL retrig_start got st %0d lvl %h want st 1 lvl %h", st1, lv1, exp0);
        end
      end
      if (c == 64) begin
        vectors++;
        if (lv1 !== exp0 + 16'h1000) begin
          miscompares++;
          $display("FAIL retrig_step got %h want %h", lv1, exp0 + 16'h1000);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if (c % 100 == 0) begin
        attack_rate   = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
        decay_rate    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
        release_rate  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
        sustain_level = 16'($urandom);
      end
      if ($urandom_range(0, 29) == 0) gate = ~gate;
      if ($urandom_range(0, 63) == 0) sustain_level = 16'($urandom);
      sample_in = 16'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs(i) !== mexp(i)) begin
          miscompares++;
          $display("FAIL random inst%0d cyc %0d got %h want %h", i, c, obs(i), mexp(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_instant();
    test_prescaler();
    test_vca();
    test_retrigger();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
